// File: rtl/microc_subr.sv
// Single-cycle microcontroller datapath: PC/next-PC with a hardware call/return stack, 16 x DATA_W regfile, ALU, immediate mux, zero flag.
// Latency: every architectural update lands on the next rising clk edge; opcode is combinational from instr.
// Backpressure: none; the datapath accepts one instruction per cycle with no stall or handshake.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   instr               16-bit instruction word fetched from the ROM at address pc
//   s_inc/s_call/s_ret  next-PC selection strobes from the control unit
//   s_inm, we3, op      write-back source select, register write enable, ALU operation
//   pc, opcode          ROM address and instr[5:0] returned to the control unit
//   z                   registered zero flag from the last ALU write-back
//   stack_err           sticky flag for stack overflow, underflow or a call/return conflict
//   sp_level            number of return addresses currently held on the stack
module microc_subr #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              s_inc,
    input  logic              s_inm,
    input  logic              we3,
    input  logic [2:0]        op,
    input  logic              s_call,
    input  logic              s_ret,
    output logic [PC_W-1:0]   pc,
    output logic [5:0]        opcode,
    output logic              z,
    output logic              stack_err,
    output logic [SP_W-1:0]   sp_level
);

    localparam int IDX_W = $clog2(STACK_DEPTH);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]        wa3;
    logic [3:0]        ra1;
    logic [3:0]        ra2;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   target;

    assign wa3    = instr[15:12];
    assign ra1    = instr[11:8];
    assign ra2    = instr[7:4];
    assign imm    = DATA_W'(instr[11:4]);
    assign target = instr[15:16-PC_W];
    assign opcode = instr[5:0];

    // ------------------------------------------------------------------
    // Register file: r0 is hardwired to zero on the read side, and writes
    // to it are dropped. Reads see the pre-edge contents, so an instruction
    // that reads and writes the same register uses the old value.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wd3;

    assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
    assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];
    assign wd3 = s_inm ? imm : alu_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we3 && (wa3 != 4'd0)) begin
            rf_q[wa3] <= wd3;
        end
    end

    // ------------------------------------------------------------------
    // ALU: all results wrap modulo 2^DATA_W
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (op)
            3'b000:  alu_res = rd1;
            3'b001:  alu_res = ~rd1;
            3'b010:  alu_res = rd1 + rd2;
            3'b011:  alu_res = rd1 - rd2;
            3'b100:  alu_res = rd1 & rd2;
            3'b101:  alu_res = rd1 | rd2;
            3'b110:  alu_res = '0 - rd1;
            default: alu_res = '0 - rd2;
        endcase
    end

    // ------------------------------------------------------------------
    // Zero flag: only ALU write-backs update it; immediate loads leave it.
    // ------------------------------------------------------------------
    logic z_q;
    logic z_d;

    always_comb begin
        z_d = z_q;
        if (we3 && !s_inm) begin
            z_d = (alu_res == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;

    // ------------------------------------------------------------------
    // PC and return-address stack
    // sp_q counts occupied entries, so the next free slot is stk_q[sp_q]
    // and the top of stack is stk_q[sp_q-1].
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pc_plus1;
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic             err_q;
    logic             err_d;
    logic             push;
    logic             stack_empty;
    logic             stack_full;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [PC_W-1:0]  stk_q [STACK_DEPTH];

    assign pc_plus1    = pc_q + PC_W'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = IDX_W'(sp_q - SP_W'(1));

    // Priority: conflict, return (underflow or pop), call (overflow or
    // push), then plain jump vs. increment. Faulting call/return requests
    // fall through to PC+1 so execution carries on past the bad instruction.
    always_comb begin
        pc_d  = pc_plus1;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (s_call && s_ret) begin
            err_d = 1'b1;
        end else if (s_ret) begin
            if (stack_empty) begin
                err_d = 1'b1;
            end else begin
                pc_d = stk_q[pop_idx];
                sp_d = sp_q - SP_W'(1);
            end
        end else if (s_call) begin
            if (stack_full) begin
                err_d = 1'b1;
            end else begin
                push = 1'b1;
                pc_d = target;
                sp_d = sp_q + SP_W'(1);
            end
        end else if (!s_inc) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage needs no reset: entries are only read below sp_q.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stk_q[push_idx] <= pc_plus1;
        end
    end

    assign pc        = pc_q;
    assign sp_level  = sp_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_microc_subr.sv
// Testbench for microc_subr: directed instruction sequences, a behavioural
// reference model checked every cycle, and hand-computed literal checks.
module tb_microc_subr;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        s_inc;
    logic        s_inm;
    logic        we3;
    logic [2:0]  op;
    logic        s_call;
    logic        s_ret;
    logic [9:0]  pc;
    logic [5:0]  opcode;
    logic        z;
    logic        stack_err;
    logic [3:0]  sp_level;

    int checks = 0;
    int errors = 0;

    microc_subr #(.DATA_W(8), .PC_W(10), .STACK_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .s_inc     (s_inc),
        .s_inm     (s_inm),
        .we3       (we3),
        .op        (op),
        .s_call    (s_call),
        .s_ret     (s_ret),
        .pc        (pc),
        .opcode    (opcode),
        .z         (z),
        .stack_err (stack_err),
        .sp_level  (sp_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: integer arithmetic and a queue for the stack.
    // ------------------------------------------------------------------
    int m_rf [16];
    int m_pc;
    int m_z;
    int m_err;
    int m_stk [$];
    bit m_valid = 1'b0;
    int ma, mb, mres, mt;

    always @(posedge clk) begin
        if (reset) begin
            m_pc  = 0;
            m_z   = 0;
            m_err = 0;
            m_stk.delete();
            for (int i = 0; i < 16; i++) m_rf[i] = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ma = m_rf[instr[11:8]];
            mb = m_rf[instr[7:4]];
            case (op)
                3'd0: mres = ma;
                3'd1: mres = ~ma;
                3'd2: mres = ma + mb;
                3'd3: mres = ma - mb;
                3'd4: mres = ma & mb;
                3'd5: mres = ma | mb;
                3'd6: mres = -ma;
                default: mres = -mb;
            endcase
            mres = mres & 255;
            if (we3 && !s_inm) m_z = (mres == 0) ? 1 : 0;
            if (we3 && instr[15:12] != 4'd0)
                m_rf[instr[15:12]] = s_inm ? int'(instr[11:4]) : mres;
            mt = int'(instr[15:6]);
            if (s_call && s_ret) begin
                m_pc  = m_pc + 1;
                m_err = 1;
            end else if (s_ret) begin
                if (m_stk.size() == 0) begin
                    m_pc  = m_pc + 1;
                    m_err = 1;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (s_call) begin
                if (m_stk.size() == 8) begin
                    m_pc  = m_pc + 1;
                    m_err = 1;
                end else begin
                    m_stk.push_back((m_pc + 1) % 1024);
                    m_pc = mt;
                end
            end else if (!s_inc) begin
                m_pc = mt;
            end else begin
                m_pc = m_pc + 1;
            end
            m_pc = m_pc % 1024;
        end
    end

    // Per-cycle comparison on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", int'(pc), m_pc);
            chk("model_z", int'(z), m_z);
            chk("model_stack_err", int'(stack_err), m_err);
            chk("model_sp_level", int'(sp_level), m_stk.size());
            chk("model_opcode", int'(opcode), int'(instr[5:0]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after a rising edge.
    // ------------------------------------------------------------------
    task automatic cyc(input logic [15:0] i, input logic inc, input logic inm,
                       input logic w, input logic [2:0] o, input logic c, input logic r);
        instr  = i;
        s_inc  = inc;
        s_inm  = inm;
        we3    = w;
        op     = o;
        s_call = c;
        s_ret  = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        s_inc = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
    endtask

    task automatic nop();
        cyc(16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic ld_imm(input logic [3:0] rd, input logic [7:0] val);
        cyc({rd, val, 4'h0}, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [2:0] o);
        cyc({rd, ra, rb, 4'h0}, 1'b1, 1'b0, 1'b1, o, 1'b0, 1'b0);
    endtask

    task automatic call(input logic [9:0] t);
        cyc({t, 6'b0}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic ret();
        cyc(16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic jmp(input logic [9:0] t);
        cyc({t, 6'b0}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // r1=0x0C, r2=0x0A: expected result of each ALU op, indexed by op.
    logic [7:0] alu_exp [8] = '{8'h0C, 8'hF3, 8'h16, 8'h02, 8'h08, 8'h0E, 8'hF4, 8'hF6};

    initial begin
        clk    = 1'b0;
        reset  = 1'b1;
        instr  = 16'h0000;
        s_inc  = 1'b1;
        s_inm  = 1'b0;
        we3    = 1'b0;
        op     = 3'd0;
        s_call = 1'b0;
        s_ret  = 1'b0;

        // T1: reset state, every register reads zero (A==0 sets z)
        do_reset(2);
        chk("rst_pc", int'(pc), 0);
        chk("rst_z", int'(z), 0);
        chk("rst_sp", int'(sp_level), 0);
        chk("rst_err", int'(stack_err), 0);
        for (int i = 1; i < 16; i++) begin
            alu(4'd0, 4'(i), 4'd0, 3'd0);
            chk($sformatf("rst_r%0d_zero", i), int'(z), 1);
        end

        // T2: immediates, sub/add, z behaviour
        ld_imm(4'd1, 8'h05);
        ld_imm(4'd2, 8'h05);
        alu(4'd3, 4'd1, 4'd2, 3'd3);
        chk("sub_z", int'(z), 1);
        alu(4'd4, 4'd1, 4'd2, 3'd2);
        chk("add_z", int'(z), 0);
        ld_imm(4'd5, 8'h00);
        chk("imm_keeps_z", int'(z), 0);
        ld_imm(4'd7, 8'h0A);
        alu(4'd0, 4'd4, 4'd7, 3'd3);
        chk("r4_is_0a", int'(z), 1);
        alu(4'd1, 4'd1, 4'd1, 3'd2);
        chk("r1_dbl_z", int'(z), 0);
        alu(4'd0, 4'd1, 4'd7, 3'd3);
        chk("r1_old_read", int'(z), 1);

        // All eight ALU ops, verified by subtracting the expected value
        ld_imm(4'd1, 8'h0C);
        ld_imm(4'd2, 8'h0A);
        for (int k = 0; k < 8; k++) begin
            alu(4'd8, 4'd1, 4'd2, 3'(k));
            ld_imm(4'd9, alu_exp[k]);
            alu(4'd0, 4'd8, 4'd9, 3'd3);
            chk($sformatf("alu_op%0d", k), int'(z), 1);
        end

        // T3: nested call/return
        do_reset(1);
        repeat (3) nop();
        chk("t3_pc3", int'(pc), 3);
        call(10'h020);
        chk("t3_call1_pc", int'(pc), 'h20);
        chk("t3_call1_sp", int'(sp_level), 1);
        nop();
        call(10'h030);
        chk("t3_call2_pc", int'(pc), 'h30);
        chk("t3_call2_sp", int'(sp_level), 2);
        ret();
        chk("t3_ret1_pc", int'(pc), 'h22);
        ret();
        chk("t3_ret2_pc", int'(pc), 4);
        chk("t3_ret2_sp", int'(sp_level), 0);
        chk("t3_err", int'(stack_err), 0);

        // T4: overflow then full unwind
        do_reset(1);
        for (int k = 0; k < 8; k++) call(10'(12'h100 + k * 16));
        chk("t4_full_sp", int'(sp_level), 8);
        chk("t4_full_pc", int'(pc), 'h170);
        chk("t4_full_err", int'(stack_err), 0);
        call(10'h200);
        chk("t4_ovf_pc", int'(pc), 'h171);
        chk("t4_ovf_sp", int'(sp_level), 8);
        chk("t4_ovf_err", int'(stack_err), 1);
        ret();
        chk("t4_ret1_pc", int'(pc), 'h161);
        repeat (7) ret();
        chk("t4_unwind_pc", int'(pc), 1);
        chk("t4_unwind_sp", int'(sp_level), 0);
        chk("t4_unwind_err", int'(stack_err), 1);

        // T5: underflow and call/return conflict
        do_reset(1);
        repeat (7) nop();
        ret();
        chk("t5_unf_pc", int'(pc), 8);
        chk("t5_unf_err", int'(stack_err), 1);
        chk("t5_unf_sp", int'(sp_level), 0);
        do_reset(1);
        chk("t5_err_cleared", int'(stack_err), 0);
        call(10'h040);
        cyc(16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        chk("t5_cfl_pc", int'(pc), 'h41);
        chk("t5_cfl_sp", int'(sp_level), 1);
        chk("t5_cfl_err", int'(stack_err), 1);

        // T6: r0 writes ignored, PC wrap, reset during a call sequence
        do_reset(1);
        ld_imm(4'd1, 8'h05);
        alu(4'd0, 4'd1, 4'd0, 3'd0);
        chk("t6_r1_nz", int'(z), 0);
        ld_imm(4'd0, 8'hFF);
        alu(4'd0, 4'd0, 4'd0, 3'd0);
        chk("t6_r0_zero", int'(z), 1);
        jmp(10'h3FF);
        chk("t6_jmp_pc", int'(pc), 'h3FF);
        nop();
        chk("t6_wrap_pc", int'(pc), 0);
        call(10'h050);
        call(10'h060);
        chk("t6_mid_sp", int'(sp_level), 2);
        do_reset(1);
        chk("t6_rst_pc", int'(pc), 0);
        chk("t6_rst_sp", int'(sp_level), 0);
        nop();
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
